audio_beep_dac: RTL and testbench

AUDIO_BEEP_DAC -- requirements
Module: audio_beep_dac

---
 rtl/audio_pkg.sv | 35 +++
 rtl/beep_pattern_gen.sv | 116 +++++++++++
 rtl/audio_beep_dac.sv | 130 +++++++++++++
 tb/tb_audio_beep_dac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared defaults and cadence helpers for the beep DAC.
// Defaults give a 48.83 kHz frame rate and a 1017 Hz tone.
package audio_pkg;

    localparam int DEF_BCLK_HALF    = 16;
    localparam int DEF_TONE_HALF    = 24;
    localparam int DEF_UNIT_SAMPLES = 1024;
    localparam int DEF_ON_UNITS     = 4;
    localparam int FRAME_BITS       = 16;

    // Cadence period length in units for a latched distance code.
    function automatic logic [7:0] periodUnits(input logic [3:0] code, input int onUnits);
        logic [7:0] units;
        if ((code == 4'd0) || (code == 4'd15)) begin
            units = 8'd1;
        end else begin
            units = 8'(onUnits) + 8'd2 * (8'd15 - {4'd0, code});
        end
        return units;
    endfunction

    // Whether a given unit of the period belongs to the on-phase.
    function automatic logic unitIsOn(input logic [3:0] code, input logic [7:0] unit, input int onUnits);
        logic on;
        if (code == 4'd15) begin
            on = 1'b1;
        end else if (code == 4'd0) begin
            on = 1'b0;
        end else begin
            on = (int'(unit) < onUnits);
        end
        return on;
    endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// Cadence and tone generator: presents the sample to be latched at the next
// strobe and advances its counters on that strobe.
module beep_pattern_gen
    import audio_pkg::*;
#(
    parameter int TONE_HALF    = DEF_TONE_HALF,
    parameter int UNIT_SAMPLES = DEF_UNIT_SAMPLES,
    parameter int ON_UNITS     = DEF_ON_UNITS
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTB,
    input  logic        iEN,
    input  logic [3:0]  iDIST_CODE,
    input  logic [15:0] iAMP,
    output logic [15:0] oSAMPLE,
    output logic        oBEEP_ON
);

    localparam int SW = $clog2(UNIT_SAMPLES + 1);
    localparam int TW = $clog2(TONE_HALF + 1);

    logic [SW-1:0] sampCnt_r;
    logic [7:0]    unitCnt_r;
    logic [3:0]    codeQ_r;
    logic [TW-1:0] toneCnt_r;
    logic          tonePh_r;
    logic          prevOn_r;

    logic          periodStart_s;
    logic [3:0]    codeEff_s;
    logic [7:0]    periodLen_s;
    logic          onEff_s;
    logic [TW-1:0] curCnt_s;
    logic          curPh_s;
    logic [15:0]   mag_s;

    // Decode the sample for the current position; at a period start the live code applies.
    always_comb begin
        periodStart_s = (sampCnt_r == '0) && (unitCnt_r == 8'd0);
        if (periodStart_s) begin
            codeEff_s = iDIST_CODE;
        end else begin
            codeEff_s = codeQ_r;
        end
        periodLen_s = periodUnits(codeEff_s, ON_UNITS);
        onEff_s     = iEN && unitIsOn(codeEff_s, unitCnt_r, ON_UNITS);
        if (onEff_s && !prevOn_r) begin
            curCnt_s = '0;
            curPh_s  = 1'b1;
        end else begin
            curCnt_s = toneCnt_r;
            curPh_s  = tonePh_r;
        end
        if (iAMP[15]) begin
            mag_s = 16'h7FFF;
        end else begin
            mag_s = iAMP;
        end
        if (!onEff_s) begin
            oSAMPLE = 16'h0000;
        end else if (curPh_s) begin
            oSAMPLE = mag_s;
        end else begin
            oSAMPLE = (~mag_s) + 16'h0001;
        end
        oBEEP_ON = onEff_s;
    end

    // Advance sample/unit/tone counters once per latched sample.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sampCnt_r <= '0;
            unitCnt_r <= 8'd0;
            codeQ_r   <= 4'd0;
            toneCnt_r <= '0;
            tonePh_r  <= 1'b0;
            prevOn_r  <= 1'b0;
        end else if (iSTB) begin
            if (!iEN) begin
                sampCnt_r <= '0;
                unitCnt_r <= 8'd0;
                codeQ_r   <= 4'd0;
                toneCnt_r <= '0;
                tonePh_r  <= 1'b0;
                prevOn_r  <= 1'b0;
            end else begin
                if (periodStart_s) begin
                    codeQ_r <= iDIST_CODE;
                end
                if (sampCnt_r == SW'(UNIT_SAMPLES - 1)) begin
                    sampCnt_r <= '0;
                    if (unitCnt_r == periodLen_s - 8'd1) begin
                        unitCnt_r <= 8'd0;
                    end else begin
                        unitCnt_r <= unitCnt_r + 8'd1;
                    end
                end else begin
                    sampCnt_r <= sampCnt_r + SW'(1);
                end
                prevOn_r <= onEff_s;
                if (!onEff_s) begin
                    toneCnt_r <= '0;
                    tonePh_r  <= 1'b0;
                end else if (curCnt_s == TW'(TONE_HALF - 1)) begin
                    toneCnt_r <= '0;
                    tonePh_r  <= ~curPh_s;
                end else begin
                    toneCnt_r <= curCnt_s + TW'(1);
                    tonePh_r  <= curPh_s;
                end
            end
        end
    end

endmodule

// File: rtl/audio_beep_dac.sv
// Beep-tone source for a left-justified 16-bit codec DAC: generates XCK, BCLK
// and LRCK from iCLK and serializes the pattern generator's samples.
module audio_beep_dac
    import audio_pkg::*;
#(
    parameter int BCLK_HALF    = DEF_BCLK_HALF,
    parameter int TONE_HALF    = DEF_TONE_HALF,
    parameter int UNIT_SAMPLES = DEF_UNIT_SAMPLES,
    parameter int ON_UNITS     = DEF_ON_UNITS
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iEN,
    input  logic [3:0]  iDIST_CODE,
    input  logic [15:0] iAMP,
    output logic        AUD_XCK,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        oSAMPLE_STB,
    output logic        oBEEP_ON
);

    localparam int BW = $clog2(BCLK_HALF + 1);

    logic [BW-1:0] bclkCnt_r;
    logic          xckDiv_r;
    logic [3:0]    bitCnt_r;
    logic [15:0]   sample_r;

    logic          bclkToggle_s;
    logic          bclkFall_s;
    logic          lrckToggle_s;
    logic          sampleTick_s;
    logic [15:0]   genSample_s;
    logic          genBeepOn_s;

    // Edge qualifiers; sampleTick_s marks the cycle whose clock edge raises LRCK.
    always_comb begin
        bclkToggle_s = (bclkCnt_r == BW'(BCLK_HALF - 1));
        bclkFall_s   = bclkToggle_s && AUD_BCLK;
        lrckToggle_s = bclkFall_s && (bitCnt_r == 4'(FRAME_BITS - 1));
        sampleTick_s = lrckToggle_s && !AUD_DACLRCK;
    end

    // Codec master clock at iCLK/4.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            xckDiv_r <= 1'b0;
            AUD_XCK  <= 1'b0;
        end else begin
            xckDiv_r <= ~xckDiv_r;
            if (xckDiv_r) begin
                AUD_XCK <= ~AUD_XCK;
            end
        end
    end

    // Bit clock divider.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bclkCnt_r <= '0;
            AUD_BCLK  <= 1'b0;
        end else if (bclkToggle_s) begin
            bclkCnt_r <= '0;
            AUD_BCLK  <= ~AUD_BCLK;
        end else begin
            bclkCnt_r <= bclkCnt_r + BW'(1);
        end
    end

    // Bit index and frame clock, both advanced on BCLK falling edges.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bitCnt_r    <= 4'd0;
            AUD_DACLRCK <= 1'b0;
        end else if (lrckToggle_s) begin
            bitCnt_r    <= 4'd0;
            AUD_DACLRCK <= ~AUD_DACLRCK;
        end else if (bclkFall_s) begin
            bitCnt_r <= bitCnt_r + 4'd1;
        end
    end

    // Serializer: MSB leaves with the LRCK edge, the rest on later falling edges.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sample_r   <= 16'h0000;
            AUD_DACDAT <= 1'b0;
        end else if (sampleTick_s) begin
            sample_r   <= genSample_s;
            AUD_DACDAT <= genSample_s[15];
        end else if (lrckToggle_s) begin
            AUD_DACDAT <= sample_r[15];
        end else if (bclkFall_s) begin
            AUD_DACDAT <= sample_r[4'd14 - bitCnt_r];
        end
    end

    // Sample strobe and beep status, aligned with the latched sample.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSAMPLE_STB <= 1'b0;
            oBEEP_ON    <= 1'b0;
        end else begin
            oSAMPLE_STB <= sampleTick_s;
            if (sampleTick_s) begin
                oBEEP_ON <= genBeepOn_s;
            end else if (!iEN) begin
                oBEEP_ON <= 1'b0;
            end
        end
    end

    beep_pattern_gen #(
        .TONE_HALF    (TONE_HALF),
        .UNIT_SAMPLES (UNIT_SAMPLES),
        .ON_UNITS     (ON_UNITS)
    ) uPattern (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iSTB       (sampleTick_s),
        .iEN        (iEN),
        .iDIST_CODE (iDIST_CODE),
        .iAMP       (iAMP),
        .oSAMPLE    (genSample_s),
        .oBEEP_ON   (genBeepOn_s)
    );

endmodule

// File: tb/tb_audio_beep_dac.sv
// Scoreboard bench for audio_beep_dac with shortened cadence parameters.
module tb_audio_beep_dac;

    localparam int BH    = 2;
    localparam int TH    = 3;
    localparam int US    = 4;
    localparam int OU    = 4;
    localparam int FRAME = 64 * BH;
    localparam int HALFF = 32 * BH;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iEN = 1'b0;
    logic [3:0]  iDIST_CODE = 4'd0;
    logic [15:0] iAMP = 16'h0000;
    logic        AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, oSAMPLE_STB, oBEEP_ON;

    always #5 iCLK = ~iCLK;

    audio_beep_dac #(
        .BCLK_HALF    (BH),
        .TONE_HALF    (TH),
        .UNIT_SAMPLES (US),
        .ON_UNITS     (OU)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iEN         (iEN),
        .iDIST_CODE  (iDIST_CODE),
        .iAMP        (iAMP),
        .AUD_XCK     (AUD_XCK),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .oSAMPLE_STB (oSAMPLE_STB),
        .oBEEP_ON    (oBEEP_ON)
    );

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    logic [15:0] sbQ[$];
    int          runsQ[$];
    int          mPos, mToneIdx, mCode, runLen;
    logic        mPrevOn, expOn, haveLeft, runVal, quietChk;
    logic [15:0] expW, lastExp, word;
    int          expRuns[4] = '{OU * US, 2 * US, OU * US, 28 * US};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic resetBench();
        cyc = 0; sbQ.delete(); runsQ.delete();
        mPos = 0; mToneIdx = 0; mCode = 0; mPrevOn = 1'b0;
        expW = 16'h0000; expOn = 1'b0; lastExp = 16'h0000; word = 16'h0000;
        haveLeft = 1'b0; runVal = 1'b0; runLen = 0; quietChk = 1'b0;
    endtask

    // Reference cadence/tone model, evaluated at each LRCK rising edge.
    task automatic modelTick();
        int lenS;
        logic on;
        logic [15:0] mag;
        if (!iEN) begin
            mPos = 0; mToneIdx = 0; mPrevOn = 1'b0;
            expW = 16'h0000; expOn = 1'b0;
        end else begin
            if (mPos == 0) mCode = int'(iDIST_CODE);
            if (mCode == 0 || mCode == 15) lenS = US;
            else lenS = (OU + 2 * (15 - mCode)) * US;
            on = (mCode == 15) || (mCode != 0 && mPos < OU * US);
            if (on && !mPrevOn) mToneIdx = 0;
            mag = iAMP[15] ? 16'h7FFF : iAMP;
            if (!on) expW = 16'h0000;
            else if (((mToneIdx / TH) % 2) == 0) expW = mag;
            else expW = 16'h0000 - mag;
            if (on) mToneIdx++;
            mPrevOn = on;
            expOn = on;
            mPos = (mPos + 1 == lenS) ? 0 : mPos + 1;
        end
        sbQ.push_back(expW);
    endtask

    task automatic observe();
        int rel, k;
        check("xck", AUD_XCK, 32'((cyc / 2) % 2));
        check("bclk", AUD_BCLK, 32'((cyc / BH) % 2));
        check("lrck", AUD_DACLRCK, 32'((cyc / HALFF) % 2));
        if (cyc % FRAME == HALFF) begin
            check("stb_hi", oSAMPLE_STB, 1);
            check("msb_at_lrck", AUD_DACDAT, expW[15]);
            check("beep_on", oBEEP_ON, expOn);
            if (oBEEP_ON == runVal) runLen++;
            else begin
                runsQ.push_back(runLen);
                runVal = oBEEP_ON;
                runLen = 1;
            end
        end else if (cyc % FRAME == HALFF + 1) begin
            check("stb_lo", oSAMPLE_STB, 0);
        end
        if (quietChk) check("dat_quiet", AUD_DACDAT, 0);
        if (cyc > HALFF && cyc % (2 * BH) == BH) begin
            rel  = (cyc - HALFF) % FRAME;
            k    = (rel % HALFF) / (2 * BH);
            word = {word[14:0], AUD_DACDAT};
            if (k == 15) begin
                if (rel < HALFF) begin
                    if (sbQ.size() == 0) check("sb_empty", 1, 0);
                    else begin
                        lastExp = sbQ.pop_front();
                        check("left_word", word, lastExp);
                        haveLeft = 1'b1;
                    end
                end else if (haveLeft) begin
                    check("right_word", word, lastExp);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        cyc++;
        if (cyc % FRAME == HALFF) modelTick();
        #1;
        observe();
    endtask

    task automatic samples(input int n);
        repeat (n * FRAME) step();
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_xck"}, AUD_XCK, 0);
        check({tag, "_bclk"}, AUD_BCLK, 0);
        check({tag, "_lrck"}, AUD_DACLRCK, 0);
        check({tag, "_dat"}, AUD_DACDAT, 0);
        check({tag, "_stb"}, oSAMPLE_STB, 0);
        check({tag, "_beep"}, oBEEP_ON, 0);
    endtask

    initial begin
        resetBench();
        repeat (3) @(posedge iCLK);
        #1;
        checkOutputsZero("rst");
        @(negedge iCLK);
        iRST_N = 1'b1;

        // Disabled: clocks only, silent data.
        quietChk = 1'b1;
        samples(3);
        repeat (HALFF + 17) step();
        quietChk = 1'b0;

        // Continuous tone, then saturated amplitude.
        iEN = 1'b1; iDIST_CODE = 4'd15; iAMP = 16'h1234;
        samples(20);
        iAMP = 16'hFFFF;
        samples(8);

        // Code 14 cadence, then switch to code 1 early in an on-phase.
        iAMP = 16'h1234; iDIST_CODE = 4'd14;
        samples(52);
        for (int i = 0; i < 60 * FRAME; i++) begin
            if (mPos == 2 && mCode == 14) break;
            step();
        end
        check("wait_on_phase", 32'(mPos == 2 && mCode == 14), 1);
        iDIST_CODE = 4'd1;
        runsQ.delete();
        samples(160);
        for (int i = 0; i < 4; i++) begin
            check("run_len", (i < runsQ.size()) ? 32'(runsQ[i]) : 32'hFFFF_FFFF, 32'(expRuns[i]));
        end

        // Enable dropped and restored mid-frame.
        iDIST_CODE = 4'd14;
        for (int i = 0; i < FRAME; i++) begin
            if (cyc % FRAME == HALFF + 20) break;
            step();
        end
        iEN = 1'b0;
        samples(3);
        repeat (40) step();
        iEN = 1'b1;
        samples(30);

        // Asynchronous reset mid-frame.
        repeat (37) step();
        #1 iRST_N = 1'b0;
        #1 checkOutputsZero("async_rst");
        @(negedge iCLK);
        iRST_N = 1'b1;
        resetBench();
        samples(10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
